fetch_unit: RTL and testbench

Instruction-fetch stage that computes the next-PC value fed to the pc register and consumes that register's current value (pc_result) to address instruction memory. It handles the multi-cycle instruction-memory handshake, branch/jump redirects, ID-stage stalls and flushes. It also owns the IF/ID pipeline register (instruction, PC+4, valid).

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_unit_next_pc_sel.sv | 37 +++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch state encoding
package cpu_pkg;

    localparam int PC_W    = 13;
    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    localparam logic [PC_W-1:0]    RESET_PC  = 13'h0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// rtl/fetch_unit_next_pc_sel.sv - next-PC priority mux for the fetch stage
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic            in_reset_i,
    input  logic            take_redir_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    input  logic [PC_W-1:0] jump_target_i,
    input  logic            drain_done_i,
    input  logic [PC_W-1:0] redir_pc_i,
    input  logic            accept_i,
    input  logic [PC_W-1:0] pc_result_i,
    input  logic [PC_W-1:0] pc_plus_i,
    output logic [PC_W-1:0] redir_target_o,
    output logic [PC_W-1:0] pc_next_o
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    // Branch resolves in EX, so it belongs to an older instruction than an ID jump.
    assign redir_target_o = (branch_taken_i ? branch_target_i : jump_target_i) & ALIGN_MASK;

    always_comb begin
        pc_next_o = pc_result_i;
        if (in_reset_i) begin
            pc_next_o = RESET_PC;
        end else if (take_redir_i) begin
            pc_next_o = redir_target_o;
        end else if (drain_done_i) begin
            pc_next_o = redir_pc_i;
        end else if (accept_i) begin
            pc_next_o = pc_plus_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with imem handshake and IF/ID register
module fetch_unit
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_result,
    output logic [PC_W-1:0]    pc_next,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               jump_taken,
    input  logic [PC_W-1:0]    jump_target,
    input  logic               stall_d,
    input  logic               flush,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc4
);

    fetch_state_e        state_q, state_d;
    logic [PC_W-1:0]     redir_pc_q, redir_pc_d;
    logic                valid_q, valid_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [PC_W-1:0]     pc4_q, pc4_d;

    logic                redirect;
    logic                req;
    logic                accept;
    logic                take_redir;
    logic                drain_done;
    logic [PC_W-1:0]     redir_target;
    logic [PC_W-1:0]     pc_plus;

    assign redirect  = branch_taken | jump_taken;
    assign pc_plus   = pc_result + PC_W'(PC_INC);
    assign imem_addr = pc_result;
    assign imem_req  = reset & req;

    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        req        = 1'b0;
        accept     = 1'b0;
        take_redir = 1'b0;
        drain_done = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                req = ~stall_d & ~redirect;
                if (redirect) begin
                    take_redir = 1'b1;
                end else if (req && imem_ready) begin
                    accept = ~flush;
                end else if (req) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (imem_ready) begin
                    state_d = S_FETCH;
                    if (redirect) begin
                        take_redir = 1'b1;
                    end else begin
                        accept = ~stall_d & ~flush;
                    end
                end else if (redirect) begin
                    // Address must stay put until the old response arrives.
                    redir_pc_d = redir_target;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                req = 1'b1;
                if (imem_ready) begin
                    state_d = S_FETCH;
                    if (redirect) begin
                        take_redir = 1'b1;
                    end else begin
                        drain_done = 1'b1;
                    end
                end else if (redirect) begin
                    redir_pc_d = redir_target;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (accept) begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            pc4_d   = pc_plus;
        end
        if (redirect || flush) begin
            valid_d = 1'b0;
        end
    end

    next_pc_sel u_next_pc_sel (
        .in_reset_i      (~reset),
        .take_redir_i    (take_redir),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_target_i   (jump_target),
        .drain_done_i    (drain_done),
        .redir_pc_i      (redir_pc_q),
        .accept_i        (accept),
        .pc_result_i     (pc_result),
        .pc_plus_i       (pc_plus),
        .redir_target_o  (redir_target),
        .pc_next_o       (pc_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            redir_pc_q <= '0;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc4_q      <= '0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
        end
    end

    assign if_id_valid = valid_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] pc_result, pc_next, imem_addr, branch_target, jump_target, if_id_pc4;
    logic        imem_req, imem_ready, branch_taken, jump_taken, stall_d, flush, if_id_valid;
    logic [31:0] imem_rdata, if_id_instr;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pc_result     (pc_result),
        .pc_next       (pc_next),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_taken    (jump_taken),
        .jump_target   (jump_target),
        .stall_d       (stall_d),
        .flush         (flush),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4)
    );

    typedef struct {
        int          cyc;
        logic [12:0] nxt;
        logic        req;
        logic [12:0] addr;
        logic        v;
        logic [31:0] instr;
        logic [12:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;

    // Reference model: outstanding-request bookkeeping plus the architectural IF/ID contents.
    bit          m_wait = 0;
    bit          m_drain = 0;
    bit          m_v = 0;
    logic [12:0] m_tgt = '0;
    logic [12:0] m_pc4 = '0;
    logic [31:0] m_instr = '0;
    logic [12:0] m_pcn = '0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, expv);
        end
    endtask

    task automatic cyc(input bit rst_n, input bit rdy, input bit st, input bit fl,
                       input bit br, input logic [12:0] bt, input bit jp, input logic [12:0] jt);
        exp_t        e;
        logic [12:0] pc, tgt, pc4;
        logic [31:0] data;
        bit          red;
        @(posedge clk);
        #1;
        cycle++;
        data = $urandom;
        pc   = m_pcn;
        reset = rst_n; imem_ready = rdy; imem_rdata = data; stall_d = st; flush = fl;
        branch_taken = br; branch_target = bt; jump_taken = jp; jump_target = jt;
        pc_result = pc;

        red = br | jp;
        tgt = (br ? bt : jt) & 13'h1FFC;
        pc4 = 13'((int'(pc) + 4) % 8192);

        if (!rst_n) begin
            m_wait = 0; m_drain = 0; m_v = 0; m_instr = '0; m_pc4 = '0; m_tgt = '0;
        end
        e.cyc = cycle; e.addr = pc; e.v = m_v; e.instr = m_instr; e.pc4 = m_pc4;
        e.nxt = pc; e.req = 1'b0;

        if (!rst_n) begin
            e.nxt = 13'h0000;
        end else if (m_drain) begin
            e.req = 1'b1;
            if (red) m_v = 0;
            if (fl) m_v = 0;
            if (rdy) begin
                e.nxt = red ? tgt : m_tgt;
                m_drain = 0;
            end else if (red) begin
                m_tgt = tgt;
            end
        end else if (m_wait) begin
            e.req = 1'b1;
            if (rdy) begin
                m_wait = 0;
                if (red) begin
                    e.nxt = tgt; m_v = 0;
                end else if (st || fl) begin
                    if (fl) m_v = 0;
                end else begin
                    m_v = 1; m_instr = data; m_pc4 = pc4; e.nxt = pc4;
                end
            end else if (red) begin
                m_tgt = tgt; m_drain = 1; m_wait = 0; m_v = 0;
            end else if (fl) begin
                m_v = 0;
            end
        end else begin
            e.req = !st && !red;
            if (red) begin
                e.nxt = tgt; m_v = 0;
            end else if (st) begin
                if (fl) m_v = 0;
            end else if (rdy) begin
                if (fl) m_v = 0;
                else begin
                    m_v = 1; m_instr = data; m_pc4 = pc4; e.nxt = pc4;
                end
            end else begin
                m_wait = 1;
                if (fl) m_v = 0;
            end
        end

        m_pcn = e.nxt;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_next",     e.cyc, 32'(pc_next),     32'(e.nxt));
                chk("imem_req",    e.cyc, 32'(imem_req),    32'(e.req));
                chk("imem_addr",   e.cyc, 32'(imem_addr),   32'(e.addr));
                chk("if_id_valid", e.cyc, 32'(if_id_valid), 32'(e.v));
                chk("if_id_instr", e.cyc, if_id_instr,      e.instr);
                chk("if_id_pc4",   e.cyc, 32'(if_id_pc4),   32'(e.pc4));
            end
        end
    end

    initial begin : stimulus
        reset = 1'b0; imem_ready = 1'b0; imem_rdata = '0; stall_d = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = '0; jump_taken = 1'b0; jump_target = '0;
        pc_result = '0;

        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc(1, 1, 0, 0, 0, 0, 0, 0);

        // Two-cycle memory latency at 0x010
        cyc(1, 0, 0, 0, 0, 0, 1, 13'h010);
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);

        // Branch while waiting on 0x020 forces a drain
        cyc(1, 0, 0, 0, 0, 0, 1, 13'h020);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 13'h104, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 1, 0, 0, 0, 0, 0, 0);

        cyc(1, 1, 0, 0, 1, 13'h040, 1, 13'h080);
        repeat (2) cyc(1, 1, 0, 0, 0, 0, 0, 0);

        repeat (3) cyc(1, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0, 0, 0);
        repeat (2) cyc(1, 1, 0, 0, 0, 0, 0, 0);

        cyc(1, 1, 0, 0, 0, 0, 1, 13'h1FFC);
        repeat (3) cyc(1, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(99) != 0, $urandom_range(99) < 60, $urandom_range(99) < 15,
                $urandom_range(99) < 8, $urandom_range(99) < 6, 13'($urandom),
                $urandom_range(99) < 6, 13'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty", cycle, 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
